// File: rtl/tdc_packetizer_pkg.sv
// tdc_packetizer_pkg: shared constants, serializer state encoding and helpers
// for the TDC result packetizer.
package tdc_packetizer_pkg;

   // Frame header byte, first byte of every frame
   localparam logic [7:0]  PKT_HDR        = 8'hA5;

   // Default parameterisation
   localparam int unsigned DEF_DATA_W     = 16;
   localparam int unsigned DEF_DEPTH_LOG2 = 4;

   // Sequence tag and drop counter widths
   localparam int unsigned SEQ_W          = 8;
   localparam int unsigned DROP_W         = 8;

   // Serializer states (fixed encoding, kept stable for downstream tooling)
   localparam logic [1:0]  ST_IDLE        = 2'd0;
   localparam logic [1:0]  ST_HDR         = 2'd1;
   localparam logic [1:0]  ST_SEQ         = 2'd2;
   localparam logic [1:0]  ST_DATA        = 2'd3;

   // Number of whole bytes needed to carry a w-bit result
   function automatic int unsigned nbytes(input int unsigned w);
      return (w + 7) / 8;
   endfunction

endpackage

// File: rtl/tdc_sync_fifo.sv
// tdc_sync_fifo: parametric single-clock FIFO with registered read data.
//   iClk, iRst_n : clock, asynchronous active-low reset
//   iWrEn/iWrData: push request and data (ignored while full)
//   iRdEn        : pop request (ignored while empty)
//   oRdData      : read data, valid the cycle after a pop, held until next pop
//   oFull_c      : full flag, decoded from the pointers
//   oEmpty_c     : empty flag, decoded from the pointers
//   oLevel       : registered occupancy, 0..2^DEPTH_LOG2
module tdc_sync_fifo #(
   parameter int unsigned WIDTH      = 24,
   parameter int unsigned DEPTH_LOG2 = 4
) (
   input  logic                  iClk,
   input  logic                  iRst_n,
   input  logic                  iWrEn,
   input  logic [WIDTH-1:0]      iWrData,
   input  logic                  iRdEn,
   output logic [WIDTH-1:0]      oRdData,
   output logic                  oFull_c,
   output logic                  oEmpty_c,
   output logic [DEPTH_LOG2:0]   oLevel
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam int unsigned PTR_W = DEPTH_LOG2 + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wptr_q;
   logic [PTR_W-1:0] rptr_q;
   logic [PTR_W-1:0] level_q;
   logic [WIDTH-1:0] rd_data_q;
   logic             wr_ok_c;
   logic             rd_ok_c;

   // Extra pointer bit distinguishes full from empty when the indices match
   assign oEmpty_c = (wptr_q == rptr_q);
   assign oFull_c  = (wptr_q[DEPTH_LOG2] != rptr_q[DEPTH_LOG2]) &&
                     (wptr_q[DEPTH_LOG2-1:0] == rptr_q[DEPTH_LOG2-1:0]);

   assign wr_ok_c  = iWrEn && !oFull_c;
   assign rd_ok_c  = iRdEn && !oEmpty_c;

   // Storage array, no reset needed on the data itself
   always_ff @(posedge iClk) begin
      if (wr_ok_c) begin
         mem[wptr_q[DEPTH_LOG2-1:0]] <= iWrData;
      end
   end

   // Pointers, occupancy and registered read port
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         wptr_q    <= '0;
         rptr_q    <= '0;
         level_q   <= '0;
         rd_data_q <= '0;
      end else begin
         if (wr_ok_c) begin
            wptr_q <= wptr_q + PTR_W'(1);
         end
         if (rd_ok_c) begin
            rptr_q    <= rptr_q + PTR_W'(1);
            rd_data_q <= mem[rptr_q[DEPTH_LOG2-1:0]];
         end
         case ({wr_ok_c, rd_ok_c})
            2'b10:   level_q <= level_q + PTR_W'(1);
            2'b01:   level_q <= level_q - PTR_W'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   assign oRdData = rd_data_q;
   assign oLevel  = level_q;

endmodule

// File: rtl/tdc_packetizer.sv
// tdc_packetizer: buffers finished TDC results, tags them with a sequence
// number and streams them as framed bytes {A5, seq, data MSB-first}.
//   iClk, iRst_n : clock, asynchronous active-low reset
//   iTDC, iDone  : measurement word and its one-cycle strobe
//   oByte/oValid : byte stream toward the host link, iReady accepts a byte
//   oLevel       : FIFO occupancy
//   oOverflow    : sticky drop flag, oDropCnt saturating drop count
//   iClrOvf      : synchronous clear of oOverflow and oDropCnt
module tdc_packetizer
   import tdc_packetizer_pkg::*;
#(
   parameter int unsigned DATA_W     = DEF_DATA_W,
   parameter int unsigned DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
   input  logic                  iClk,
   input  logic                  iRst_n,
   input  logic [DATA_W-1:0]     iTDC,
   input  logic                  iDone,
   output logic [7:0]            oByte,
   output logic                  oValid,
   input  logic                  iReady,
   output logic [DEPTH_LOG2:0]   oLevel,
   output logic                  oOverflow,
   output logic [DROP_W-1:0]     oDropCnt,
   input  logic                  iClrOvf
);

   localparam int unsigned NBYTES  = nbytes(DATA_W);
   localparam int unsigned ENTRY_W = SEQ_W + DATA_W;
   localparam int unsigned PAD_W   = NBYTES * 8;
   localparam int unsigned IDX_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   logic [SEQ_W-1:0]   seq_q;
   logic               ovf_q;
   logic [DROP_W-1:0]  drop_cnt_q;

   logic               fifo_full_c;
   logic               fifo_empty_c;
   logic               wr_en_c;
   logic               drop_c;
   logic               rd_en_c;
   logic [ENTRY_W-1:0] rd_data;

   logic [1:0]         state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [7:0]         byte_q, byte_d;
   logic               valid_q, valid_d;
   logic [DATA_W-1:0]  hold_q;
   logic               xfer_c;

   // Select byte idx of the zero-extended result (idx 0 = least significant)
   function automatic logic [7:0] data_byte(input logic [DATA_W-1:0] d,
                                            input logic [IDX_W-1:0]  idx);
      logic [PAD_W-1:0] padded;
      padded = PAD_W'(d);
      return 8'(padded >> {idx, 3'b000});
   endfunction

   // Capture: full is judged before the edge, so a same-cycle pop never rescues a write
   assign wr_en_c = iDone && !fifo_full_c;
   assign drop_c  = iDone && fifo_full_c;

   tdc_sync_fifo #(
      .WIDTH      (ENTRY_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .iClk     (iClk),
      .iRst_n   (iRst_n),
      .iWrEn    (wr_en_c),
      .iWrData  ({seq_q, iTDC}),
      .iRdEn    (rd_en_c),
      .oRdData  (rd_data),
      .oFull_c  (fifo_full_c),
      .oEmpty_c (fifo_empty_c),
      .oLevel   (oLevel)
   );

   // Sequence tag advances on every strobe, dropped or not
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         seq_q <= '0;
      end else if (iDone) begin
         seq_q <= seq_q + SEQ_W'(1);
      end
   end

   // Drop tracking; a clear wins over a coincident drop
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         ovf_q      <= 1'b0;
         drop_cnt_q <= '0;
      end else if (iClrOvf) begin
         ovf_q      <= 1'b0;
         drop_cnt_q <= '0;
      end else if (drop_c) begin
         ovf_q <= 1'b1;
         if (drop_cnt_q != '1) begin
            drop_cnt_q <= drop_cnt_q + DROP_W'(1);
         end
      end
   end

   assign oOverflow = ovf_q;
   assign oDropCnt  = drop_cnt_q;

   assign xfer_c = valid_q && iReady;

   // Serializer next state; the output byte is computed one step ahead so it is registered
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      byte_d  = byte_q;
      valid_d = valid_q;
      rd_en_c = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            valid_d = 1'b0;
            if (!fifo_empty_c) begin
               rd_en_c = 1'b1;
               state_d = ST_HDR;
               byte_d  = PKT_HDR;
               valid_d = 1'b1;
            end
         end
         ST_HDR: begin
            // Read data arrived this cycle, take the tag straight from the FIFO port
            if (xfer_c) begin
               state_d = ST_SEQ;
               byte_d  = rd_data[ENTRY_W-1 -: SEQ_W];
            end
         end
         ST_SEQ: begin
            if (xfer_c) begin
               state_d = ST_DATA;
               idx_d   = IDX_W'(NBYTES - 1);
               byte_d  = data_byte(hold_q, IDX_W'(NBYTES - 1));
            end
         end
         ST_DATA: begin
            if (xfer_c) begin
               if (idx_q != '0) begin
                  idx_d  = idx_q - IDX_W'(1);
                  byte_d = data_byte(hold_q, idx_q - IDX_W'(1));
               end else if (!fifo_empty_c) begin
                  rd_en_c = 1'b1;
                  state_d = ST_HDR;
                  byte_d  = PKT_HDR;
               end else begin
                  state_d = ST_IDLE;
                  byte_d  = 8'h00;
                  valid_d = 1'b0;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            byte_d  = 8'h00;
            valid_d = 1'b0;
         end
      endcase
   end

   // Serializer state, output and holding registers
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         byte_q  <= 8'h00;
         valid_q <= 1'b0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         byte_q  <= byte_d;
         valid_q <= valid_d;
         if (state_q == ST_HDR) begin
            hold_q <= rd_data[DATA_W-1:0];
         end
      end
   end

   assign oByte  = byte_q;
   assign oValid = valid_q;

endmodule

// File: tb/tb_tdc_packetizer.sv
// tb_tdc_packetizer: directed test of tdc_packetizer against a queue-based
// model of the captured entries and of the frame currently on the wire.
module tb_tdc_packetizer;

   localparam int DATA_W     = 16;
   localparam int DEPTH_LOG2 = 4;
   localparam int DEPTH      = 16;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic [DATA_W-1:0]   iTDC = '0;
   logic                iDone = 1'b0;
   logic                iReady = 1'b1;
   logic                iClrOvf = 1'b0;
   logic [7:0]          oByte;
   logic                oValid;
   logic [DEPTH_LOG2:0] oLevel;
   logic                oOverflow;
   logic [7:0]          oDropCnt;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   // Model state
   logic [23:0] mq[$];
   logic [7:0]  cur[$];
   logic [7:0]  m_seq;
   logic        m_ovf;
   logic [7:0]  m_cnt;
   logic        m_pop;
   logic        m_full;
   logic [23:0] m_e;

   // Observed stream log
   logic [7:0]  rx[$];
   int          rx_cyc[$];
   logic [7:0]  expq[$];
   int          cyc = 0;
   int          done_cyc = 0;
   logic        stall_prev = 1'b0;
   logic [7:0]  byte_prev = 8'h00;

   always #5 clk = ~clk;

   tdc_packetizer #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) dut (
      .iClk      (clk),
      .iRst_n    (rst_n),
      .iTDC      (iTDC),
      .iDone     (iDone),
      .oByte     (oByte),
      .oValid    (oValid),
      .iReady    (iReady),
      .oLevel    (oLevel),
      .oOverflow (oOverflow),
      .oDropCnt  (oDropCnt),
      .iClrOvf   (iClrOvf)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: entries queue up until the serializer is free, then become a 4-byte frame
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         cur.delete();
         m_seq      = 8'h00;
         m_ovf      = 1'b0;
         m_cnt      = 8'h00;
         stall_prev = 1'b0;
      end else begin
         if (oValid && iReady) begin
            rx.push_back(oByte);
            rx_cyc.push_back(cyc);
         end
         stall_prev = oValid && !iReady;
         byte_prev  = oByte;
         if (iDone) done_cyc = cyc;

         m_pop  = (mq.size() > 0) && ((cur.size() == 0) || (cur.size() == 1 && iReady));
         m_full = (mq.size() == DEPTH);
         if (cur.size() > 0 && iReady) void'(cur.pop_front());
         if (m_pop) begin
            m_e = mq.pop_front();
            cur = {8'hA5, m_e[23:16], m_e[15:8], m_e[7:0]};
         end
         if (iDone) begin
            if (!m_full) mq.push_back({m_seq, iTDC});
            m_seq = m_seq + 8'd1;
         end
         if (iClrOvf) begin
            m_ovf = 1'b0;
            m_cnt = 8'h00;
         end else if (iDone && m_full) begin
            m_ovf = 1'b1;
            if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
         end
         cyc++;
      end
   end

   // Cycle-by-cycle compare against the model
   always @(posedge clk) begin
      #1;
      if (rst_n) begin
         check("valid", 32'(oValid), 32'(cur.size() > 0));
         if (cur.size() > 0) check("byte", 32'(oByte), 32'(cur[0]));
         check("level", 32'(oLevel), 32'(mq.size()));
         check("overflow", 32'(oOverflow), 32'(m_ovf));
         check("dropcnt", 32'(oDropCnt), 32'(m_cnt));
         if (stall_prev) check("stable", 32'(oByte), 32'(byte_prev));
      end
   end

   task automatic pulse(input logic [15:0] v);
      iTDC  = v;
      iDone = 1'b1;
      @(negedge clk);
      iDone = 1'b0;
   endtask

   task automatic wait_idle(input string name, input bit toggle);
      bit idle;
      idle = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (mq.size() == 0 && cur.size() == 0) begin
            idle = 1'b1;
            break;
         end
         if (toggle) iReady = ~iReady;
         @(negedge clk);
      end
      check(name, 32'(idle), 32'd1);
      iReady = 1'b1;
      @(negedge clk);
   endtask

   task automatic check_stream(input string name);
      check({name, "_len"}, 32'(rx.size()), 32'(expq.size()));
      for (int i = 0; i < expq.size(); i++) begin
         if (i < rx.size()) check(name, 32'(rx[i]), 32'(expq[i]));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      check("rst_byte", 32'(oByte), 32'h00);
      check("rst_valid", 32'(oValid), 32'h0);
      check("rst_level", 32'(oLevel), 32'h0);
      check("rst_ovf", 32'(oOverflow), 32'h0);
      check("rst_cnt", 32'(oDropCnt), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single result
      rx.delete(); rx_cyc.delete();
      pulse(16'h1234);
      wait_idle("single_idle", 1'b0);
      expq = {8'hA5, 8'h00, 8'h12, 8'h34};
      check_stream("single");
      if (rx_cyc.size() >= 4) begin
         check("single_first_lat", 32'(rx_cyc[0] - done_cyc), 32'd2);
         check("single_last_lat", 32'(rx_cyc[3] - done_cyc), 32'd5);
      end
      check("single_level", 32'(oLevel), 32'd0);

      // Backpressure with ready toggling
      rx.delete(); rx_cyc.delete();
      pulse(16'h1234);
      wait_idle("bp_idle", 1'b1);
      expq = {8'hA5, 8'h01, 8'h12, 8'h34};
      check_stream("bp");

      // Back-to-back frames
      rx.delete(); rx_cyc.delete();
      pulse(16'h0001);
      pulse(16'h0002);
      pulse(16'h0003);
      wait_idle("b2b_idle", 1'b0);
      expq = {8'hA5, 8'h02, 8'h00, 8'h01, 8'hA5, 8'h03, 8'h00, 8'h02,
              8'hA5, 8'h04, 8'h00, 8'h03};
      check_stream("b2b");
      if (rx_cyc.size() >= 12) check("b2b_gapless", 32'(rx_cyc[11] - rx_cyc[0]), 32'd11);

      // Overflow: seq 00 already sits in the serializer, 16 fill the FIFO, 3 drop
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      iReady = 1'b0;
      for (int i = 0; i < 20; i++) pulse(16'(16'h0100 + i));
      @(negedge clk);
      check("ovf_level", 32'(oLevel), 32'd16);
      check("ovf_cnt", 32'(oDropCnt), 32'd3);
      check("ovf_flag", 32'(oOverflow), 32'd1);
      rx.delete(); rx_cyc.delete();
      iReady = 1'b1;
      wait_idle("ovf_idle", 1'b0);
      check("ovf_len", 32'(rx.size()), 32'd68);
      for (int k = 0; k < 17; k++) begin
         if (4 * k + 3 < rx.size()) begin
            check("ovf_hdr", 32'(rx[4*k]), 32'hA5);
            check("ovf_seq", 32'(rx[4*k+1]), 32'(k));
            check("ovf_data", 32'(rx[4*k+3]), 32'(k));
         end
      end
      rx.delete(); rx_cyc.delete();
      pulse(16'h0042);
      wait_idle("next_idle", 1'b0);
      expq = {8'hA5, 8'h14, 8'h00, 8'h42};
      check_stream("next_seq");

      // Clear colliding with a drop
      iReady = 1'b0;
      for (int i = 0; i < 17; i++) pulse(16'(16'h0200 + i));
      check("clr_full", 32'(oLevel), 32'd16);
      iTDC = 16'hDEAD; iDone = 1'b1; iClrOvf = 1'b1;
      @(negedge clk);
      iDone = 1'b0; iClrOvf = 1'b0;
      check("clr_flag", 32'(oOverflow), 32'd0);
      check("clr_cnt", 32'(oDropCnt), 32'd0);
      pulse(16'hDEAD);
      check("drop_after_clr", 32'(oDropCnt), 32'd1);
      iClrOvf = 1'b1;
      @(negedge clk);
      iClrOvf = 1'b0;
      check("clr_alone", 32'(oDropCnt), 32'd0);

      // Reset while the seq byte is on the wire
      iReady = 1'b1;
      @(posedge clk);
      @(negedge clk);
      iReady = 1'b0;
      check("pre_rst_valid", 32'(oValid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_async_valid", 32'(oValid), 32'd0);
      check("rst_async_level", 32'(oLevel), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      iReady = 1'b1;
      rx.delete(); rx_cyc.delete();
      pulse(16'hBEEF);
      wait_idle("post_rst_idle", 1'b0);
      expq = {8'hA5, 8'h00, 8'hBE, 8'hEF};
      check_stream("post_rst");

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
